// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one single-port ROM between instruction-fetch (IF)
// and data-read (DM) ports, with latency tracking, IF flush and a conflict counter.
module rom_port_arbiter #(
  parameter int  D_WIDTH     = 32,
  parameter int  MEM_DEPTH   = 1024,
  parameter int  ROM_LATENCY = 0,
  parameter int  CNT_WIDTH   = 16,
  localparam int A_WIDTH     = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [A_WIDTH-1:0]   if_addr,
  input  logic                 if_flush,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [D_WIDTH-1:0]   if_rdata,
  input  logic                 dm_req,
  input  logic [A_WIDTH-1:0]   dm_addr,
  output logic                 dm_gnt,
  output logic                 dm_rvalid,
  output logic [D_WIDTH-1:0]   dm_rdata,
  output logic                 rom_en,
  output logic [A_WIDTH-1:0]   rom_addr,
  input  logic [D_WIDTH-1:0]   rom_dout,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_e;

  port_e                last_grant;
  logic                 if_cand;
  logic                 if_ret;
  logic                 dm_ret;
  logic [ROM_LATENCY:0] pipe_valid;
  logic [ROM_LATENCY:0] pipe_dm;

  // A flushing IF port cannot compete; reset withholds all grants.
  always_comb begin
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    if_cand = if_req & ~if_flush;
    if (reset) begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end else if (if_cand && dm_req) begin
      if (last_grant == PORT_DM) begin
        if_gnt = 1'b1;
      end else begin
        dm_gnt = 1'b1;
      end
    end else if (if_cand) begin
      if_gnt = 1'b1;
    end else if (dm_req) begin
      dm_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  // Round-robin history; idle cycles leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_DM;
    end else if (if_gnt) begin
      last_grant <= PORT_IF;
    end else if (dm_gnt) begin
      last_grant <= PORT_DM;
    end else begin
      last_grant <= last_grant;
    end
  end

  // Registered ROM strobe/address; address holds across idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_en   <= 1'b0;
      rom_addr <= {A_WIDTH{1'b0}};
    end else begin
      rom_en <= if_gnt | dm_gnt;
      if (if_gnt) begin
        rom_addr <= if_addr;
      end else if (dm_gnt) begin
        rom_addr <= dm_addr;
      end else begin
        rom_addr <= rom_addr;
      end
    end
  end

  // Stage k holds the read whose data appears on rom_dout k cycles after rom_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= {(ROM_LATENCY+1){1'b0}};
      pipe_dm    <= {(ROM_LATENCY+1){1'b0}};
    end else begin
      pipe_valid[0] <= if_gnt | dm_gnt;
      pipe_dm[0]    <= dm_gnt;
      for (int k = 1; k <= ROM_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1] & ~(if_flush & ~pipe_dm[k-1]);
        pipe_dm[k]    <= pipe_dm[k-1];
      end
    end
  end

  // The read completing this cycle is dropped too when it belongs to a flushed IF.
  assign if_ret = pipe_valid[ROM_LATENCY] & ~pipe_dm[ROM_LATENCY] & ~if_flush;
  assign dm_ret = pipe_valid[ROM_LATENCY] &  pipe_dm[ROM_LATENCY];

  // Steer returned word to its owner; the other port's data holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= {D_WIDTH{1'b0}};
      dm_rdata  <= {D_WIDTH{1'b0}};
    end else begin
      if_rvalid <= if_ret;
      dm_rvalid <= dm_ret;
      if (if_ret) begin
        if_rdata <= rom_dout;
      end else begin
        if_rdata <= if_rdata;
      end
      if (dm_ret) begin
        dm_rdata <= rom_dout;
      end else begin
        dm_rdata <= dm_rdata;
      end
    end
  end

  // Saturating count of cycles where both ports contend.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= {CNT_WIDTH{1'b0}};
    end else if (if_req && dm_req && !if_flush && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
      conflict_cnt <= conflict_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      conflict_cnt <= conflict_cnt;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench: two DUTs (ROM_LATENCY 0 / 3, CNT_WIDTH 16 / 4) share randomized
// stimulus; a per-instance reference model predicts grants and returns.
module tb_rom_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0, reset = 1'b1;
  logic          if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  int            cyc = 0, n_cmp = 0, n_fail = 0;
  bit            armed = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    if (a == 10'h010) return 32'hDEADBEEF;
    return {a, 22'h0} ^ (32'(a) * 32'h0001_0193) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L  = (g == 0) ? 0 : 3;
    localparam int CW = (g == 0) ? 16 : 4;
    logic          if_gnt, dm_gnt, if_rvalid, dm_rvalid, rom_en;
    logic [DW-1:0] if_rdata, dm_rdata, rom_dout;
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] conflict_cnt;

    rom_port_arbiter #(.D_WIDTH(DW), .MEM_DEPTH(1024), .ROM_LATENCY(L), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_addr(dm_addr), .dm_gnt(dm_gnt),
      .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .conflict_cnt(conflict_cnt)
    );

    if (L == 0) begin : g_rom_comb
      assign rom_dout = rom_word(rom_addr);
    end else begin : g_rom_seq
      logic [DW-1:0] dl [0:L-1];
      always @(posedge clk) begin
        dl[0] <= rom_word(rom_addr);
        for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
      end
      assign rom_dout = dl[L-1];
    end

    // Expected returns: data and the cycle in which rvalid must be visible.
    logic [DW-1:0] qd_if[$], qd_dm[$];
    int            qr_if[$], qr_dm[$];
    bit            last_dm = 1'b1;
    logic          exp_en = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    int            exp_cnt = 0;

    always @(negedge clk) begin : model
      bit wi, wd, ir;
      ir = if_req && !if_flush;
      wi = 1'b0;
      wd = 1'b0;
      if (!reset) begin
        if (ir && dm_req) begin
          wi = last_dm;
          wd = !last_dm;
        end else begin
          wi = ir;
          wd = dm_req;
        end
      end
      if (armed) begin
        check($sformatf("i%0d if_gnt", g), 32'(if_gnt), 32'(wi));
        check($sformatf("i%0d dm_gnt", g), 32'(dm_gnt), 32'(wd));
        check($sformatf("i%0d rom_en", g), 32'(rom_en), 32'(exp_en));
        check($sformatf("i%0d rom_addr", g), 32'(rom_addr), 32'(exp_addr));
        check($sformatf("i%0d conflict_cnt", g), 32'(conflict_cnt), exp_cnt);
      end
      if (reset) begin
        last_dm = 1'b1; exp_en = 1'b0; exp_addr = '0; exp_cnt = 0;
        while (qr_if.size() > 0 && qr_if[qr_if.size()-1] > cyc) begin
          void'(qr_if.pop_back()); void'(qd_if.pop_back());
        end
        while (qr_dm.size() > 0 && qr_dm[qr_dm.size()-1] > cyc) begin
          void'(qr_dm.pop_back()); void'(qd_dm.pop_back());
        end
      end else begin
        if (if_flush) begin
          while (qr_if.size() > 0 && qr_if[qr_if.size()-1] > cyc) begin
            void'(qr_if.pop_back()); void'(qd_if.pop_back());
          end
        end
        if (if_req && dm_req && !if_flush && exp_cnt < (1 << CW) - 1) exp_cnt++;
        exp_en = wi | wd;
        if (wi) begin
          exp_addr = if_addr; last_dm = 1'b0;
          qd_if.push_back(rom_word(if_addr)); qr_if.push_back(cyc + L + 2);
        end
        if (wd) begin
          exp_addr = dm_addr; last_dm = 1'b1;
          qd_dm.push_back(rom_word(dm_addr)); qr_dm.push_back(cyc + L + 2);
        end
      end
    end

    always @(negedge clk) begin : monitor
      if (armed) begin
        if (if_rvalid === 1'b1) begin
          if (qd_if.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL i%0d if_rvalid: actual=1 required=0 (cycle %0d)", g, cyc);
          end else begin
            check($sformatf("i%0d if_rdata", g), if_rdata, qd_if.pop_front());
            check($sformatf("i%0d if_latency", g), cyc, qr_if.pop_front());
          end
        end else if (qr_if.size() > 0 && qr_if[0] <= cyc) begin
          n_cmp++; n_fail++;
          $display("FAIL i%0d if_rvalid: actual=0 required=1 (cycle %0d)", g, cyc);
          void'(qr_if.pop_front()); void'(qd_if.pop_front());
        end
        if (dm_rvalid === 1'b1) begin
          if (qd_dm.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL i%0d dm_rvalid: actual=1 required=0 (cycle %0d)", g, cyc);
          end else begin
            check($sformatf("i%0d dm_rdata", g), dm_rdata, qd_dm.pop_front());
            check($sformatf("i%0d dm_latency", g), cyc, qr_dm.pop_front());
          end
        end else if (qr_dm.size() > 0 && qr_dm[0] <= cyc) begin
          n_cmp++; n_fail++;
          $display("FAIL i%0d dm_rvalid: actual=0 required=1 (cycle %0d)", g, cyc);
          void'(qr_dm.pop_front()); void'(qd_dm.pop_front());
        end
      end
    end
  end

  // Requester hold rule: a pending request keeps req and addr until granted.
  logic          p_ireq = 1'b0, p_ignt = 1'b0, p_dreq = 1'b0, p_dgnt = 1'b0, p_rst = 1'b1;
  logic [AW-1:0] p_iaddr = '0, p_daddr = '0;
  always @(negedge clk) begin
    if (armed && !reset && !p_rst) begin
      if ((p_ireq && !p_ignt && (!if_req || if_addr != p_iaddr)) ||
          (p_dreq && !p_dgnt && (!dm_req || dm_addr != p_daddr))) begin
        n_fail++;
        $display("FAIL protocol: request dropped or address changed before grant (cycle %0d)", cyc);
      end
    end
    p_ireq = if_req; p_ignt = g_inst[0].if_gnt; p_iaddr = if_addr;
    p_dreq = dm_req; p_dgnt = g_inst[0].dm_gnt; p_daddr = dm_addr; p_rst = reset;
  end

  logic [AW-1:0] if_q[$], dm_q[$];
  int            start_pct = 100, if_gcnt = 0, dm_gcnt = 0;

  task automatic drive_reqs();
    if (!if_req) if_req = (if_q.size() > 0) && ($urandom_range(99) < start_pct);
    else         if_req = (if_q.size() > 0);
    if (if_req) if_addr = if_q[0];
    if (!dm_req) dm_req = (dm_q.size() > 0) && ($urandom_range(99) < start_pct);
    else         dm_req = (dm_q.size() > 0);
    if (dm_req) dm_addr = dm_q[0];
  endtask

  task automatic tick();
    bit ig, dg;
    @(negedge clk);
    ig = g_inst[0].if_gnt;
    dg = g_inst[0].dm_gnt;
    @(posedge clk);
    #1;
    if (ig) begin void'(if_q.pop_front()); if_gcnt++; end
    if (dg) begin void'(dm_q.pop_front()); dm_gcnt++; end
    drive_reqs();
  endtask

  task automatic do_reset();
    reset = 1'b1; if_flush = 1'b0;
    if_q.delete(); dm_q.delete();
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int b;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    check("rst i0 if_rdata", g_inst[0].if_rdata, 32'h0);
    check("rst i0 dm_rdata", g_inst[0].dm_rdata, 32'h0);
    check("rst i1 if_rdata", g_inst[1].if_rdata, 32'h0);
    check("rst i1 dm_rvalid", 32'(g_inst[1].dm_rvalid), 32'h0);

    // single IF read of the 0xDEADBEEF word
    @(posedge clk); #1;
    if_q.push_back(10'h010); drive_reqs();
    repeat (8) tick();

    // both ports contending from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if_q.push_back(AW'(i)); dm_q.push_back(AW'(100 + i));
    end
    drive_reqs();
    repeat (10) tick();
    check("overlap conflict_cnt", 32'(g_inst[0].conflict_cnt), 32'd5);

    // IF streaming words 4..7
    for (int i = 4; i < 8; i++) if_q.push_back(AW'(i));
    drive_reqs();
    repeat (12) tick();

    // flush one cycle after the second IF grant, DM arriving in the flush cycle
    b = if_gcnt;
    for (int i = 20; i < 28; i++) if_q.push_back(AW'(i));
    drive_reqs();
    for (int i = 0; i < 20 && if_gcnt < b + 2; i++) tick();
    check("flush setup grants", 32'(if_gcnt - b), 32'd2);
    if_flush = 1'b1; dm_q.push_back(10'd200); drive_reqs();
    tick();
    if_flush = 1'b0;
    repeat (16) tick();

    // reset with two reads in flight, then a fresh read
    b = if_gcnt;
    if_q.push_back(10'd30); if_q.push_back(10'd31); drive_reqs();
    for (int i = 0; i < 10 && if_gcnt < b + 2; i++) tick();
    check("reset setup grants", 32'(if_gcnt - b), 32'd2);
    do_reset();
    if_q.push_back(10'd40); drive_reqs();
    repeat (8) tick();

    // randomized traffic with occasional flushes and resets
    start_pct = 60;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(999) < 2) do_reset();
      if ($urandom_range(99) < 45 && if_q.size() < 4) if_q.push_back(AW'($urandom_range(1023)));
      if ($urandom_range(99) < 45 && dm_q.size() < 4) dm_q.push_back(AW'($urandom_range(1023)));
      if_flush = ($urandom_range(99) < 4);
      drive_reqs();
      tick();
    end
    if_flush = 1'b0;

    // saturation of the 4-bit counter
    start_pct = 100;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if_q.push_back(AW'($urandom_range(1023))); dm_q.push_back(AW'($urandom_range(1023)));
    end
    drive_reqs();
    repeat (90) tick();
    check("saturated conflict_cnt", 32'(g_inst[1].conflict_cnt), 32'd15);

    repeat (10) tick();
    check("drain i0 if", 32'(g_inst[0].qd_if.size()), 32'd0);
    check("drain i0 dm", 32'(g_inst[0].qd_dm.size()), 32'd0);
    check("drain i1 if", 32'(g_inst[1].qd_if.size()), 32'd0);
    check("drain i1 dm", 32'(g_inst[1].qd_dm.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
